// File: rtl/debounce_pkg.sv
// Shared defaults, counter-width helper and per-channel output bundle for the
// multi-channel pushbutton/switch debouncer.
package debounce_pkg;

  localparam int DEF_STABLE_CYCLES = 500000;
  localparam int DEF_HOLD_CYCLES   = 25000000;
  localparam int DEF_REPEAT_CYCLES = 5000000;

  // Bits needed to hold every value from 0 up to and including x.
  function automatic int cntWidth(input int x);
    return $clog2(x + 1);
  endfunction

  // "repeat" is a reserved word, so the auto-repeat field is repeatPulse.
  typedef struct packed {
    logic state;
    logic rise;
    logic fall;
    logic repeatPulse;
  } chOut_t;

endpackage

// File: rtl/debounce_channel.sv
// One debouncer channel: synchroniser chain, stability counter, press/release
// pulses and optional auto-repeat while held.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int REPEAT_EN     = 0,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic   iClock,
  input  logic   iReset,
  input  logic   iBouncy,
  output chOut_t oChan
);

  localparam int STABLE_W = cntWidth(STABLE_CYCLES);
  localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HOLD_W   = cntWidth(HOLD_MAX);
  localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] syncChain;
  logic                   sample;
  logic [STABLE_W-1:0]    stableCnt;
  logic                   state;
  logic                   rise;
  logic                   fall;
  logic                   commit;
  logic                   repeatOut;

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      syncChain <= '0;
    end else begin
      syncChain <= {syncChain[SYNC_STAGES-2:0], iBouncy};
    end
  end

  assign sample = syncChain[SYNC_STAGES-1];
  assign commit = (sample != state) && (stableCnt == STABLE_LAST);

  // A mismatch must persist STABLE_CYCLES consecutive cycles before the level flips.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      stableCnt <= '0;
      state     <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
    end else begin
      rise <= commit && sample;
      fall <= commit && !sample;
      if (sample == state) begin
        stableCnt <= '0;
      end else if (commit) begin
        stableCnt <= '0;
        state     <= sample;
      end else begin
        stableCnt <= stableCnt + STABLE_W'(1);
      end
    end
  end

  if (REPEAT_EN != 0) begin : genRepeat
    logic [HOLD_W-1:0] holdCnt;
    logic              repeating;
    logic              repeatPulse;
    logic              repeatHit;

    // The first pulse waits HOLD_CYCLES; later ones are spaced by REPEAT_CYCLES.
    assign repeatHit = repeating ? (holdCnt == HOLD_W'(REPEAT_CYCLES - 1))
                                 : (holdCnt == HOLD_W'(HOLD_CYCLES - 1));

    always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
        holdCnt     <= '0;
        repeating   <= 1'b0;
        repeatPulse <= 1'b0;
      end else if (!state || commit) begin
        // Press commit restarts the hold timer; release commit wins over a repeat.
        holdCnt     <= '0;
        repeating   <= 1'b0;
        repeatPulse <= 1'b0;
      end else if (repeatHit) begin
        holdCnt     <= '0;
        repeating   <= 1'b1;
        repeatPulse <= 1'b1;
      end else begin
        holdCnt     <= holdCnt + HOLD_W'(1);
        repeatPulse <= 1'b0;
      end
    end

    assign repeatOut = repeatPulse;
  end else begin : genNoRepeat
    assign repeatOut = 1'b0;
  end

  assign oChan.state       = state;
  assign oChan.rise        = rise;
  assign oChan.fall        = fall;
  assign oChan.repeatPulse = repeatOut;

endmodule

// File: rtl/multi_debouncer.sv
// N-channel debouncer between board pushbuttons/switches and the ALU entry logic;
// every channel is an independent debounce_channel instance.
module multi_debouncer
  import debounce_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int REPEAT_EN     = 0,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic            iClock,
  input  logic            iReset,
  input  logic [N_CH-1:0] iBouncy,
  output logic [N_CH-1:0] oState,
  output logic [N_CH-1:0] oRise,
  output logic [N_CH-1:0] oFall,
  output logic [N_CH-1:0] oRepeat
);

  if (SYNC_STAGES < 2) begin : genBadSync
    $error("multi_debouncer: SYNC_STAGES must be at least 2");
  end
  if (STABLE_CYCLES < 1) begin : genBadStable
    $error("multi_debouncer: STABLE_CYCLES must be at least 1");
  end

  chOut_t chOut [N_CH];

  for (genvar gi = 0; gi < N_CH; gi++) begin : genCh
    debounce_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .REPEAT_EN    (REPEAT_EN),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) uChan (
      .iClock (iClock),
      .iReset (iReset),
      .iBouncy(iBouncy[gi]),
      .oChan  (chOut[gi])
    );

    assign oState[gi]  = chOut[gi].state;
    assign oRise[gi]   = chOut[gi].rise;
    assign oFall[gi]   = chOut[gi].fall;
    assign oRepeat[gi] = chOut[gi].repeatPulse;
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed and random stimulus for multi_debouncer against a window-based
// reference model; a second instance runs with auto-repeat disabled.
module tb_multi_debouncer;

  localparam int N      = 4;
  localparam int SYNC   = 2;
  localparam int STABLE = 8;
  localparam int HOLD   = 20;
  localparam int REP    = 5;

  logic         iClock = 1'b0;
  logic         iReset;
  logic [N-1:0] iBouncy;
  logic [N-1:0] stA, riA, faA, rpA;
  logic [N-1:0] stB, riB, faB, rpB;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] rawHist [$];
  logic [N-1:0] mState, eRise, eFall, eRep;
  int           mPress [N];
  int           edgeNo;

  always #5 iClock = ~iClock;

  multi_debouncer #(
    .N_CH(N), .SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE),
    .REPEAT_EN(1), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dutA (
    .iClock(iClock), .iReset(iReset), .iBouncy(iBouncy),
    .oState(stA), .oRise(riA), .oFall(faA), .oRepeat(rpA)
  );

  multi_debouncer #(
    .N_CH(N), .SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE),
    .REPEAT_EN(0), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dutB (
    .iClock(iClock), .iReset(iReset), .iBouncy(iBouncy),
    .oState(stB), .oRise(riB), .oFall(faB), .oRepeat(rpB)
  );

  // Raw level sampled at edge k (1-based since reset release); 0 before that.
  function automatic logic rawAt(input int ch, input int k);
    if (k < 1 || k > rawHist.size()) return 1'b0;
    return rawHist[k-1][ch];
  endfunction

  // A level commits at edge k when the synchronised samples of the last STABLE
  // edges all disagree with the current level.
  task automatic modelEdge(input logic [N-1:0] v);
    rawHist.push_back(v);
    edgeNo = rawHist.size();
    for (int ch = 0; ch < N; ch++) begin
      bit ok;
      int d;
      ok = 1'b1;
      for (int j = edgeNo - SYNC - STABLE + 1; j <= edgeNo - SYNC; j++)
        if (rawAt(ch, j) == mState[ch]) ok = 1'b0;
      eRise[ch] = ok && !mState[ch];
      eFall[ch] = ok && mState[ch];
      d = edgeNo - mPress[ch];
      eRep[ch] = mState[ch] && !ok &&
                 (d == HOLD || (d > HOLD && ((d - HOLD) % REP) == 0));
      if (ok) begin
        mState[ch] = ~mState[ch];
        if (mState[ch]) mPress[ch] = edgeNo;
      end
    end
  endtask

  task automatic modelReset();
    rawHist.delete();
    edgeNo = 0;
    mState = '0;
    eRise  = '0;
    eFall  = '0;
    eRep   = '0;
    for (int ch = 0; ch < N; ch++) mPress[ch] = 0;
  endtask

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b edge=%0d", tag, obs, exp, edgeNo);
    end
  endtask

  task automatic checkAll();
    check("stateA",  stA, mState);
    check("riseA",   riA, eRise);
    check("fallA",   faA, eFall);
    check("repeatA", rpA, eRep);
    check("stateB",  stB, mState);
    check("riseB",   riB, eRise);
    check("fallB",   faB, eFall);
    check("repeatB", rpB, '0);
  endtask

  task automatic step(input logic [N-1:0] v);
    iBouncy = v;
    @(posedge iClock);
    modelEdge(v);
    #1;
    checkAll();
  endtask

  // Asserts reset between edges, checks outputs clear without a clock edge,
  // then releases away from the active edge.
  task automatic resetPulse(input string tag);
    iReset = 1'b1;
    #1;
    check({tag, "_stA"}, stA, '0);
    check({tag, "_riA"}, riA, '0);
    check({tag, "_faA"}, faA, '0);
    check({tag, "_rpA"}, rpA, '0);
    check({tag, "_stB"}, stB, '0);
    check({tag, "_riB"}, riB, '0);
    @(posedge iClock);
    @(negedge iClock);
    iReset = 1'b0;
    modelReset();
  endtask

  initial begin
    logic [N-1:0] v;
    iReset  = 1'b1;
    iBouncy = '0;
    modelReset();
    #12;
    check("rst_state",  stA, '0);
    check("rst_rise",   riA, '0);
    check("rst_fall",   faA, '0);
    check("rst_repeat", rpA, '0);
    iReset = 1'b0;

    // Clean press on channel 0, held through the following phases.
    for (int i = 1; i <= 15; i++) begin
      step(4'b0001);
      if (i == 9)  check("p1_noRiseEarly", riA, 4'b0000);
      if (i == 10) check("p1_rise10", riA, 4'b0001);
    end

    // Channel 1: short glitch, toggling noise, then a clean hold.
    for (int i = 0; i < 5; i++)  step(4'b0011);
    for (int i = 0; i < 10; i++) step(4'b0001);
    check("p2_glitchState", {3'b000, stA[1]}, 4'b0000);
    for (int i = 0; i < 30; i++) step(((i / 3) % 2 == 0) ? 4'b0011 : 4'b0001);
    for (int i = 1; i <= 15; i++) begin
      step(4'b0011);
      if (i == 9)  check("p2_noRiseEarly", {3'b000, riA[1]}, 4'b0000);
      if (i == 10) check("p2_riseAfterToggle", {3'b000, riA[1]}, 4'b0001);
    end

    // Channel 2: held long enough for auto-repeat, then released.
    for (int i = 1; i <= 50; i++) begin
      step(4'b0111);
      if (i == 10) check("p3_rise", {3'b000, riA[2]}, 4'b0001);
      if (i == 30 || i == 35 || i == 40)
        check("p3_repeat", {3'b000, rpA[2]}, 4'b0001);
      if (i == 31) check("p3_noRepeat31", {3'b000, rpA[2]}, 4'b0000);
    end
    for (int i = 1; i <= 30; i++) begin
      step(4'b0011);
      if (i == 10) check("p3_fall", {3'b000, faA[2]}, 4'b0001);
    end

    // Mid-operation reset with channel 0 still pressed.
    step(4'b0001);
    check("p4_heldBefore", {3'b000, stA[0]}, 4'b0001);
    iBouncy = 4'b0001;
    resetPulse("p4_rst");
    for (int i = 1; i <= 12; i++) begin
      step(4'b0001);
      if (i == 10) check("p4_riseAfterRst", riA, 4'b0001);
    end

    // Independent channels pressed a few cycles apart.
    iBouncy = 4'b0000;
    resetPulse("p5_rst");
    for (int i = 1; i <= 16; i++) begin
      step((i >= 4) ? 4'b1001 : 4'b0001);
      if (i == 10) check("p5_rise0", riA, 4'b0001);
      if (i == 13) check("p5_rise3", riA, 4'b1000);
    end
    check("p5_state", stA, 4'b1001);

    // Long hold on channel 2; the no-repeat instance must stay silent.
    iBouncy = 4'b0000;
    resetPulse("p6_rst");
    for (int i = 1; i <= 100; i++) begin
      step(4'b0100);
      if (i == 10) check("p6_riseB", riB, 4'b0100);
    end

    // Random bouncing on all channels.
    iBouncy = 4'b0000;
    resetPulse("p7_rst");
    v = '0;
    for (int i = 0; i < 800; i++) begin
      for (int ch = 0; ch < N; ch++)
        if ($urandom_range(0, 11) == 0) v[ch] = ~v[ch];
      step(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
